mon_adc_reader: RTL

- Serial read-back controller for the on-board 8-channel 12-bit monitoring ADC (MAX1271-style control byte, external-clock mode).
- It is the receive-direction counterpart to the comparator-threshold DAC loader. It drives chip select, serial clock and command data, shifts in the 12-bit conversion result, and presents the result with a one-cycle valid strobe to the JTAG/register side.
- It supports single-channel conversions and an automatic scan of channels 0..7.

---
 rtl/mon_adc_reader_pkg.sv | 43 ++++
 rtl/mon_adc_reader_if.sv | 25 ++
 rtl/mon_adc_frame_fsm.sv | 119 +++++++++++
 rtl/mon_adc_reader.sv | 97 +++++++++
 4 files changed

// File: rtl/mon_adc_reader_pkg.sv
// Shared definitions for the monitoring-ADC read-back path: state encoding,
// frame geometry, register bundles and the majority voter used by TMR blocks.
package mon_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_RESULT   = 3'd4
  } state_t;

  localparam int CMD_BITS   = 8;
  localparam int SKIP_BITS  = 4;
  localparam int DATA_BITS  = 12;
  localparam int FRAME_CLKS = 24;

  typedef struct packed {
    logic [7:0] div;
    logic [5:0] half;
    logic       sck;
    logic       csb;
  } fsm_cnt_t;

  localparam fsm_cnt_t CNT_RESET = '{div: 8'd0, half: 6'd0, sck: 1'b0, csb: 1'b1};

  typedef struct packed {
    logic [2:0]           chan;
    logic                 scan;
    logic [CMD_BITS-1:0]  cmd;
    logic [DATA_BITS-1:0] sreg;
    logic [2:0]           rchan;
    logic                 valid;
    logic                 scanDone;
  } top_regs_t;

  // Bitwise 2-of-3 vote; callers zero-extend into and size-cast out of 32 bits.
  function automatic logic [31:0] vote(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mon_adc_reader_if.sv
// Register-side request/result signals and the ADC serial pins of the read-back controller.
interface mon_adc_reader_if;
  logic        START;
  logic        SCAN;
  logic [2:0]  CHAN;
  logic        SDO;
  logic        SCK;
  logic        CS_B;
  logic        SDI;
  logic [11:0] RESULT;
  logic [2:0]  RESULT_CHAN;
  logic        VALID;
  logic        BUSY;
  logic        SCAN_DONE;

  modport master (
    input  START, SCAN, CHAN, SDO,
    output SCK, CS_B, SDI, RESULT, RESULT_CHAN, VALID, BUSY, SCAN_DONE
  );

  modport slave (
    output START, SCAN, CHAN, SDO,
    input  SCK, CS_B, SDI, RESULT, RESULT_CHAN, VALID, BUSY, SCAN_DONE
  );
endinterface

// File: rtl/mon_adc_frame_fsm.sv
// Frame sequencer for one ADC transaction: half-period divider, SCK/CS_B generation
// and the sample / command-shift / done strobes; optionally triplicated.
module mon_adc_frame_fsm
  import mon_adc_pkg::*;
#(
  parameter int TMR     = 0,
  parameter int CLK_DIV = 20
) (
  input  logic CLK40,
  input  logic RST,
  input  logic go_i,
  input  logic again_i,
  output logic sck_o,
  output logic cs_b_o,
  output logic busy_o,
  output logic in_result_o,
  output logic sample_o,
  output logic shift_cmd_o,
  output logic done_o
);

  localparam int         NC        = (TMR != 0) ? 3 : 1;
  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [5:0] HALF_LAST = 6'(2 * FRAME_CLKS - 1);
  localparam logic [5:0] DATA_HALF = 6'(2 * (CMD_BITS + SKIP_BITS));

  logic [NC-1:0][2:0] state_q;
  fsm_cnt_t [NC-1:0]  cnt_q;
  state_t             state_v, state_d;
  fsm_cnt_t           cnt_v, cnt_d;
  logic               tick;

  if (TMR != 0) begin : gTmr
    assign state_v = state_t'(3'(vote(32'(state_q[0]), 32'(state_q[1]), 32'(state_q[2]))));
    assign cnt_v   = fsm_cnt_t'(16'(vote(32'(cnt_q[0]), 32'(cnt_q[1]), 32'(cnt_q[2]))));
  end else begin : gPlain
    assign state_v = state_t'(state_q[0]);
    assign cnt_v   = cnt_q[0];
  end

  assign tick = (cnt_v.div == DIV_LAST);

  // Rising ticks sample SDO (data half of the frame only), falling ticks advance SDI.
  always_comb begin
    state_d     = state_v;
    cnt_d       = cnt_v;
    cnt_d.div   = tick ? 8'd0 : cnt_v.div + 8'd1;
    sample_o    = 1'b0;
    shift_cmd_o = 1'b0;
    done_o      = 1'b0;
    case (state_v)
      ST_IDLE: begin
        cnt_d.div = 8'd0;
        if (go_i) begin
          state_d   = ST_CS_SETUP;
          cnt_d.csb = 1'b0;
        end
      end
      ST_CS_SETUP: begin
        if (tick) begin
          state_d    = ST_SHIFT;
          cnt_d.half = 6'd0;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          cnt_d.sck = ~cnt_v.sck;
          if (!cnt_v.sck) sample_o = (cnt_v.half >= DATA_HALF);
          else            shift_cmd_o = 1'b1;
          if (cnt_v.half == HALF_LAST) begin
            state_d   = ST_CS_HOLD;
            cnt_d.csb = 1'b1;
          end else begin
            cnt_d.half = cnt_v.half + 6'd1;
          end
        end
      end
      ST_CS_HOLD: begin
        if (tick) begin
          state_d = ST_RESULT;
          done_o  = 1'b1;
        end
      end
      ST_RESULT: begin
        cnt_d.div = 8'd0;
        if (again_i) begin
          state_d   = ST_CS_SETUP;
          cnt_d.csb = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_RESET;
      end
    endcase
  end

  always_ff @(posedge CLK40 or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NC; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= CNT_RESET;
      end
    end else begin
      for (int i = 0; i < NC; i++) begin
        state_q[i] <= state_d;
        cnt_q[i]   <= cnt_d;
      end
    end
  end

  assign sck_o       = cnt_v.sck;
  assign cs_b_o      = cnt_v.csb;
  assign busy_o      = (state_v != ST_IDLE);
  assign in_result_o = (state_v == ST_RESULT);

endmodule

// File: rtl/mon_adc_reader.sv
// Monitoring-ADC read-back controller: command/result shift registers, channel scan
// sequencing and the result registers presented to the register side.
module mon_adc_reader
  import mon_adc_pkg::*;
#(
  parameter int         TMR      = 0,
  parameter int         CLK_DIV  = 20,
  parameter logic [3:0] CTRL_LOW = 4'b0001
) (
  input logic              CLK40,
  input logic              RST,
  mon_adc_reader_if.master bus
);

  localparam int NC = (TMR != 0) ? 3 : 1;

  top_regs_t [NC-1:0]            top_q;
  logic [NC-1:0][DATA_BITS-1:0]  result_q;
  top_regs_t                     top_v, top_d;
  logic [DATA_BITS-1:0]          result_v, result_d;

  logic go, again, busy, inResult, sample, shiftCmd, done, sck, csb;

  if (TMR != 0) begin : gTmr
    assign top_v    = top_regs_t'(29'(vote(32'(top_q[0]), 32'(top_q[1]), 32'(top_q[2]))));
    assign result_v = 12'(vote(32'(result_q[0]), 32'(result_q[1]), 32'(result_q[2])));
  end else begin : gPlain
    assign top_v    = top_q[0];
    assign result_v = result_q[0];
  end

  assign go    = ~busy & (bus.START | bus.SCAN);
  assign again = top_v.scan && (top_v.chan != 3'd7);

  mon_adc_frame_fsm #(.TMR(TMR), .CLK_DIV(CLK_DIV)) uFsm (
    .CLK40       (CLK40),
    .RST         (RST),
    .go_i        (go),
    .again_i     (again),
    .sck_o       (sck),
    .cs_b_o      (csb),
    .busy_o      (busy),
    .in_result_o (inResult),
    .sample_o    (sample),
    .shift_cmd_o (shiftCmd),
    .done_o      (done)
  );

  // SCAN has priority over START; the command byte is reloaded for every frame.
  always_comb begin
    top_d          = top_v;
    result_d       = result_v;
    top_d.valid    = 1'b0;
    top_d.scanDone = 1'b0;
    if (go) begin
      top_d.scan = bus.SCAN;
      top_d.chan = bus.SCAN ? 3'd0 : bus.CHAN;
      top_d.cmd  = {1'b1, top_d.chan, CTRL_LOW};
    end
    if (sample)   top_d.sreg = {top_v.sreg[DATA_BITS-2:0], bus.SDO};
    if (shiftCmd) top_d.cmd  = {top_v.cmd[CMD_BITS-2:0], 1'b0};
    if (done) begin
      result_d       = top_v.sreg;
      top_d.rchan    = top_v.chan;
      top_d.valid    = 1'b1;
      top_d.scanDone = top_v.scan && (top_v.chan == 3'd7);
    end
    if (inResult && again) begin
      top_d.chan = top_v.chan + 3'd1;
      top_d.cmd  = {1'b1, top_v.chan + 3'd1, CTRL_LOW};
    end
  end

  always_ff @(posedge CLK40 or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NC; i++) begin
        top_q[i]    <= '0;
        result_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NC; i++) begin
        top_q[i]    <= top_d;
        result_q[i] <= result_d;
      end
    end
  end

  assign bus.SCK         = sck;
  assign bus.CS_B        = csb;
  assign bus.SDI         = top_v.cmd[CMD_BITS-1];
  assign bus.RESULT      = result_v;
  assign bus.RESULT_CHAN = top_v.rchan;
  assign bus.VALID       = top_v.valid;
  assign bus.BUSY        = busy;
  assign bus.SCAN_DONE   = top_v.scanDone;

endmodule
